// File: rtl/av_mailbox_slave.sv
// av_mailbox_slave: Avalon-MM mailbox between a Qsys master and the MCU.
// Ports: sysclk/sysreset; av_* Avalon-MM slave (2-cycle transfers);
// data_in/data_load push m2a, data_out/data_read pop a2m (show-ahead);
// status_out/status_read give MCU status; rx_event = a2m not empty.
module av_mailbox_slave #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [1:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [15:0] av_writedata,
  output logic [15:0] av_readdata,
  output logic        av_waitrequest,
  input  logic [15:0] data_in,
  input  logic        data_load,
  output logic [15:0] data_out,
  input  logic        data_read,
  output logic [15:0] status_out,
  input  logic        status_read,
  output logic        rx_event
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;
  state_t state_q, state_d;

  logic [1:0]  cmd_addr_q;
  logic        cmd_rd_q, cmd_wr_q, cmd_empty_q;
  logic [15:0] cmd_wdata_q;
  logic [15:0] rdata_q, rdata_d, rd_mux;
  logic [15:0] scratch_q, scratch_d;
  logic        a2m_ovf_q, a2m_ovf_d;
  logic        m2a_ovf_q, m2a_ovf_d;
  logic        av_unf_q, av_unf_d;

  logic [15:0]   a2m_mem [DEPTH];
  logic [15:0]   m2a_mem [DEPTH];
  logic [AW-1:0] a2m_wp_q, a2m_rp_q;
  logic [AW-1:0] m2a_wp_q, m2a_rp_q;
  logic [CW-1:0] a2m_cnt_q, a2m_cnt_d;
  logic [CW-1:0] m2a_cnt_q, m2a_cnt_d;

  logic a2m_full, a2m_empty, m2a_full, m2a_empty;
  logic a2m_push_req, a2m_push, a2m_pop;
  logic m2a_pop_req, m2a_push, m2a_pop;
  logic start, commit, unf_set, w1c, scr_we;

  assign start  = (state_q == IDLE) & (av_read | av_write);
  assign commit = (state_q == ACK);

  assign av_waitrequest =
    sysreset | ((av_read | av_write) & (state_q != ACK));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (av_read | av_write) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a2m_full  = (a2m_cnt_q == FULL);
  assign a2m_empty = (a2m_cnt_q == '0);
  assign m2a_full  = (m2a_cnt_q == FULL);
  assign m2a_empty = (m2a_cnt_q == '0);

  // Commit uses the command captured in IDLE, not the live bus.
  // cmd_empty_q remembers an empty m2a at capture so the returned 0
  // and the underflow flag stay consistent even if the MCU loads
  // a word during ACK.
  assign a2m_push_req = commit & cmd_wr_q & (cmd_addr_q == 2'd0);
  assign m2a_pop_req  = commit & cmd_rd_q & (cmd_addr_q == 2'd0);
  assign unf_set      = m2a_pop_req & cmd_empty_q;
  assign w1c          = commit & cmd_wr_q & (cmd_addr_q == 2'd1);
  assign scr_we       = commit & cmd_wr_q & (cmd_addr_q == 2'd2);

  assign a2m_push = a2m_push_req & ~a2m_full;
  assign a2m_pop  = data_read & ~a2m_empty;
  assign m2a_push = data_load & ~m2a_full;
  assign m2a_pop  = m2a_pop_req & ~cmd_empty_q & ~m2a_empty;

  always_comb begin
    rd_mux = '0;
    case (av_address)
      2'd0: if (!m2a_empty) rd_mux = m2a_mem[m2a_rp_q];
      2'd1: begin
        rd_mux[CW-1:0] = m2a_cnt_q;
        rd_mux[5]      = a2m_full;
        rd_mux[6]      = a2m_ovf_q;
        rd_mux[7]      = av_unf_q;
      end
      2'd2:    rd_mux = scratch_q;
      default: rd_mux = '0;
    endcase
  end

  // Clears are applied before sets so a same-cycle set wins.
  always_comb begin
    rdata_d   = start & av_read ? rd_mux : rdata_q;
    scratch_d = scr_we ? cmd_wdata_q : scratch_q;
    a2m_ovf_d = a2m_ovf_q;
    av_unf_d  = av_unf_q;
    m2a_ovf_d = m2a_ovf_q;
    if (w1c & cmd_wdata_q[6]) a2m_ovf_d = 1'b0;
    if (w1c & cmd_wdata_q[7]) av_unf_d = 1'b0;
    if (status_read) m2a_ovf_d = 1'b0;
    if (a2m_push_req & a2m_full) a2m_ovf_d = 1'b1;
    if (unf_set) av_unf_d = 1'b1;
    if (data_load & m2a_full) m2a_ovf_d = 1'b1;
    a2m_cnt_d = a2m_cnt_q + CW'(a2m_push) - CW'(a2m_pop);
    m2a_cnt_d = m2a_cnt_q + CW'(m2a_push) - CW'(m2a_pop);
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= IDLE;
      cmd_addr_q  <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_empty_q <= 1'b0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      scratch_q   <= '0;
      a2m_ovf_q   <= 1'b0;
      m2a_ovf_q   <= 1'b0;
      av_unf_q    <= 1'b0;
      a2m_wp_q    <= '0;
      a2m_rp_q    <= '0;
      m2a_wp_q    <= '0;
      m2a_rp_q    <= '0;
      a2m_cnt_q   <= '0;
      m2a_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      a2m_ovf_q <= a2m_ovf_d;
      m2a_ovf_q <= m2a_ovf_d;
      av_unf_q  <= av_unf_d;
      a2m_cnt_q <= a2m_cnt_d;
      m2a_cnt_q <= m2a_cnt_d;
      if (start) begin
        cmd_addr_q  <= av_address;
        cmd_rd_q    <= av_read;
        cmd_wr_q    <= av_write;
        cmd_empty_q <= m2a_empty;
        cmd_wdata_q <= av_writedata;
      end
      if (a2m_push) a2m_wp_q <= a2m_wp_q + 1'b1;
      if (a2m_pop)  a2m_rp_q <= a2m_rp_q + 1'b1;
      if (m2a_push) m2a_wp_q <= m2a_wp_q + 1'b1;
      if (m2a_pop)  m2a_rp_q <= m2a_rp_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (a2m_push) a2m_mem[a2m_wp_q] <= cmd_wdata_q;
    if (m2a_push) m2a_mem[m2a_wp_q] <= data_in;
  end

  assign av_readdata = rdata_q;
  assign data_out    = a2m_empty ? '0 : a2m_mem[a2m_rp_q];
  assign rx_event    = ~a2m_empty;

  always_comb begin
    status_out            = '0;
    status_out[CW-1:0]    = a2m_cnt_q;
    status_out[5]         = a2m_ovf_q;
    status_out[CW+7:8]    = m2a_cnt_q;
    status_out[13]        = m2a_ovf_q;
    status_out[14]        = m2a_full;
    status_out[15]        = ~a2m_empty;
  end

endmodule

// File: doc/av_mailbox_slave.md
# av_mailbox_slave

Avalon-MM slave that lets a Qsys-side master (JTAG master, Nios, or DMA) exchange 16-bit words with the synapse316 MCU through two FIFOs. It is the responder counterpart to the MCU's Avalon master registers. It sits in the Qsys fabric on the Avalon side and on the MCU register bus on the other side. It also exports a "data waiting" line for the event controller.

## Interface
Parameters:
- DEPTH, 8, words per FIFO; power of 2, 2..16.
- CW, $clog2(DEPTH)+1, count width; derived, do not override.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- sysreset  in  1  asynchronous, active-high reset.
- av_address  in  2  Avalon word address.
- av_read  in  1  Avalon read request.
- av_write  in  1  Avalon write request.
- av_writedata  in  16  Avalon write data.
- av_readdata  out  16  Avalon read data, registered.
- av_waitrequest  out  1  Avalon wait.
- data_in  in  16  MCU load data (r_load_data).
- data_load  in  1  MCU pushes data_in into the m2a FIFO.
- data_out  out  16  head of the a2m FIFO (show-ahead); 0 when empty.
- data_read  in  1  MCU pops the a2m FIFO.
- status_out  out  16  MCU status word.
- status_read  in  1  MCU read strobe of status; clears m2a_ovf.
- rx_event  out  1  a2m FIFO not empty.

## Operation
- The a2m FIFO carries Avalon-to-MCU words. The m2a FIFO carries MCU-to-Avalon words. Each FIFO has its own count register (0..DEPTH) and wrapping read/write pointers of $clog2(DEPTH) bits.
- Avalon register map:
  - addr 0 DATA: a write pushes av_writedata to a2m. A read returns the head of m2a and pops it.
  - addr 1 STATUS read: [CW-1:0] m2a_count, [5] a2m_full, [6] a2m_ovf, [7] av_unf; other bits 0.
  - addr 1 STATUS write: write-1-to-clear on bits 6 and 7.
  - addr 2 SCRATCH: read/write, 16 bits.
  - addr 3: reads 0; writes are ignored.
- Any Avalon write to a full a2m is dropped and sets a2m_ovf (sticky).
- Any Avalon read of DATA with m2a empty returns 0x0000, does not pop, and sets av_unf (sticky).
- MCU data_load with m2a full is dropped and sets m2a_ovf (sticky).
- MCU data_read with a2m empty is ignored.
- status_out layout:
  - [CW-1:0] a2m_count.
  - [5] a2m_ovf.
  - [CW+7:8] m2a_count.
  - [13] m2a_ovf.
  - [14] m2a_full.
  - [15] a2m_nonempty.
  - All other bits 0.
- rx_event = (a2m_count != 0).
- Simultaneous push and pop on one FIFO:
  - Not full and not empty: both happen; count is unchanged.
  - Full: the push is dropped with an overflow flag; the pop happens.
  - Empty: the pop is ignored; the push happens.
- Flag set and clear in the same cycle: set wins.

## Timing
- Avalon FSM has two states, IDLE and ACK.
- IDLE:
  - On (av_read|av_write), go to ACK.
  - For a read, av_readdata is loaded with the addressed value at this edge.
- ACK:
  - av_waitrequest is low for this one cycle.
  - At the edge ending ACK, side effects commit: push, pop, SCRATCH write, or W1C.
  - The FSM then returns to IDLE.
- av_waitrequest = sysreset | ((av_read|av_write) & state!=ACK), combinational.
- Every transfer takes 2 cycles. Back-to-back transfers complete every 2 cycles.
- The master holds address, data and request until waitrequest is low (Avalon rule). The slave does not sample changes made during ACK.
- MCU side:
  - data_load and data_read take effect at the edge they are sampled high.
  - data_out, counts and status_out are updated 1 cycle later.
  - data_out is combinational from FIFO RAM/registers at the read pointer.
- Reset values:
  - av_readdata=0, state=IDLE.
  - Both FIFOs empty (pointers and counts 0).
  - All flags 0, SCRATCH=0.
  - data_out=0, status_out=0, rx_event=0.
- Reset asserted mid-transfer: FSM returns to IDLE immediately. The pending transfer has no side effect. The master sees waitrequest high until reset is released, after which it restarts normally.

## Test plan
- Avalon write 0x1234, 0xBEEF to addr 0 -> each completes in 2 cycles. After the first completes, rx_event=1. status_out[4:0]=2, data_out=0x1234. MCU data_read -> data_out=0xBEEF next cycle.
- MCU loads 0x00A5 via data_load, then the Avalon master reads addr 1, then addr 0 -> STATUS[4:0]=1, then readdata=0x00A5. STATUS afterwards reads 0.
- Avalon read addr 0 with m2a empty -> readdata=0x0000, STATUS bit7=1. Write 0x0080 to addr 1 -> bit7=0.
- DEPTH=8: 9 Avalon writes to addr 0 with no MCU reads -> a2m_count=8, status_out[5]=1 and STATUS bit6=1. data_out holds the first word. A drain via data_read returns the first 8 words in order.
- m2a full, with data_load and an Avalon DATA-read commit in the same cycle -> load dropped, m2a_ovf=1, count goes 8->7. status_read clears status_out[13].
- Assert sysreset while the FSM is in ACK of a write to addr 2 -> SCRATCH stays 0 and waitrequest=1 during reset. After release, a retried write of 0x5A5A then a read of addr 2 returns 0x5A5A.
